// File: rtl/pixel_plane_renderer_if.sv
// Pixel VRAM read port: the renderer (master) drives the address and
// receives the pixel byte from VRAM (slave) a fixed latency later.
interface pixel_plane_renderer_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_q;

    modport master (output vram_addr, input vram_q);
    modport slave  (input vram_addr, output vram_q);
endinterface

// File: rtl/pixel_plane_renderer.sv
// Streams a scaled, vertically scrolled bitmap from pixel VRAM to RGB332 video.
// Defining PIXEL_PLANE_BORDER_EN adds a border colour register for non-window pixels.
module pixel_plane_renderer #(
    parameter int H_START = 160,
    parameter int V_START = 45,
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int H_SCALE = 2,
    parameter int RD_LAT  = 1,
    parameter int ADDR_W  = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic        scale2x,
    input  logic [11:0] h_count,
    input  logic [11:0] v_count,
    input  logic [8:0]  scroll_y,
`ifdef PIXEL_PLANE_BORDER_EN
    input  logic        border_we,
    input  logic [7:0]  border_color,
`endif
    pixel_plane_renderer_if.master vram,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [1:0]  b,
    output logic        hs_o,
    output logic        vs_o
);

    localparam int LINE_W = $clog2(V_RES + 1);
    localparam int COL_W  = $clog2(H_RES + 1);
    localparam int HREP_W = $clog2(H_SCALE + 1);

    localparam logic [11:0] H_BEG  = 12'(H_START);
    localparam logic [11:0] H_END  = 12'(H_START + H_RES * H_SCALE);
    localparam logic [11:0] V_BEG  = 12'(V_START);
    localparam logic [11:0] V_PRE  = 12'(V_START - 1);
    localparam logic [11:0] V_END1 = 12'(V_START + V_RES);
    localparam logic [11:0] V_END2 = 12'(V_START + 2 * V_RES);

    typedef enum logic {WAIT_FRAME, FRAME} state_t;

    state_t              state;
    logic                s2x;
    logic [LINE_W-1:0]   src_line;
    logic [ADDR_W-1:0]   line_base;
    logic [1:0]          v_rep;
    logic [COL_W-1:0]    col;
    logic [HREP_W-1:0]   h_rep;

    logic                h_act;
    logic                v_act;
    logic                frame_start;
    logic                line_adv;
    logic                pix_act;
    logic [LINE_W-1:0]   ys;
    logic [ADDR_W-1:0]   ys_base;
    logic [COL_W-1:0]    col_eff;
    logic [HREP_W-1:0]   h_rep_eff;
    logic [1:0]          v_rep_inc;
    logic [1:0]          v_rep_lim;
    logic [LINE_W-1:0]   src_inc;

    logic [RD_LAT:0]     pix_sr;
    logic [RD_LAT+1:0]   hs_sr;
    logic [RD_LAT+1:0]   vs_sr;

    assign h_act       = (h_count >= H_BEG) && (h_count < H_END);
    assign v_act       = (v_count >= V_BEG) && (v_count < (s2x ? V_END2 : V_END1));
    assign frame_start = (v_count == V_PRE) && (h_count == 12'd0);
    assign line_adv    = v_act && (h_count == H_END) && (state == FRAME);
    assign pix_act     = h_act && v_act && !blank && (state == FRAME);

    assign ys        = LINE_W'(32'(scroll_y) % V_RES);
    assign ys_base   = ADDR_W'(32'(ys) * H_RES);
    assign v_rep_inc = v_rep + 2'd1;
    assign v_rep_lim = s2x ? 2'd2 : 2'd1;
    assign src_inc   = src_line + LINE_W'(1);

    // The first window cycle must see col 0 before the registered reset lands.
    assign col_eff   = (h_count == H_BEG) ? '0 : col;
    assign h_rep_eff = (h_count == H_BEG) ? '0 : h_rep;

    // Frame state, scroll/line bookkeeping and the registered VRAM address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_FRAME;
            s2x            <= 1'b0;
            src_line       <= '0;
            line_base      <= '0;
            v_rep          <= '0;
            col            <= '0;
            h_rep          <= '0;
            vram.vram_addr <= '0;
        end else begin
            if (frame_start) begin
                state     <= FRAME;
                s2x       <= scale2x;
                src_line  <= ys;
                line_base <= ys_base;
                v_rep     <= '0;
            end else if (line_adv) begin
                if (v_rep_inc == v_rep_lim) begin
                    v_rep <= '0;
                    if (src_inc == LINE_W'(V_RES)) begin
                        src_line  <= '0;
                        line_base <= '0;
                    end else begin
                        src_line  <= src_inc;
                        line_base <= line_base + ADDR_W'(H_RES);
                    end
                end else begin
                    v_rep <= v_rep_inc;
                end
            end

            if (h_act) begin
                if (h_rep_eff == HREP_W'(H_SCALE - 1)) begin
                    h_rep <= '0;
                    col   <= col_eff + COL_W'(1);
                end else begin
                    h_rep <= h_rep_eff + HREP_W'(1);
                    col   <= col_eff;
                end
            end

            vram.vram_addr <= h_act ? (line_base + ADDR_W'(col_eff)) : line_base;
        end
    end

`ifdef PIXEL_PLANE_BORDER_EN
    logic [7:0]      border_reg;
    logic [RD_LAT:0] bord_sr;
    logic            bord_act;

    assign bord_act = !blank && !(h_act && v_act) && (state == FRAME);

    always_ff @(posedge clk) begin
        if (reset) begin
            border_reg <= '0;
            bord_sr    <= '0;
        end else begin
            if (border_we) begin
                border_reg <= border_color;
            end
            bord_sr <= {bord_sr[RD_LAT-1:0], bord_act};
        end
    end
`endif

    // Pixel-valid travels alongside the VRAM read so it lines up with vram_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_sr    <= '0;
            hs_sr     <= '0;
            vs_sr     <= '0;
            {r, g, b} <= '0;
        end else begin
            pix_sr <= {pix_sr[RD_LAT-1:0], pix_act};
            hs_sr  <= {hs_sr[RD_LAT:0], hs};
            vs_sr  <= {vs_sr[RD_LAT:0], vs};
            if (pix_sr[RD_LAT]) begin
                {r, g, b} <= vram.vram_q;
            end
`ifdef PIXEL_PLANE_BORDER_EN
            else if (bord_sr[RD_LAT]) begin
                {r, g, b} <= border_reg;
            end
`endif
            else begin
                {r, g, b} <= '0;
            end
        end
    end

    assign hs_o = hs_sr[RD_LAT+1];
    assign vs_o = vs_sr[RD_LAT+1];

endmodule

// File: tb/tb_pixel_plane_renderer.sv
// Directed bench for pixel_plane_renderer with RD_LAT=2 (L=4); VRAM returns addr[7:0].
`timescale 1ns/1ps
module tb_pixel_plane_renderer;

    localparam int H_START = 160;
    localparam int V_START = 45;
    localparam int H_RES   = 320;
    localparam int V_RES   = 240;
    localparam int H_SCALE = 2;
    localparam int RD_LAT  = 2;
    localparam int ADDR_W  = 17;
    localparam int L       = RD_LAT + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        scale2x;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic [8:0]  scroll_y;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic        hs_o;
    logic        vs_o;
`ifdef PIXEL_PLANE_BORDER_EN
    logic        border_we;
    logic [7:0]  border_color;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  bord = 8'h00;
    logic [7:0]  pix_hist [L];
    logic        hs_hist  [L];
    logic        vs_hist  [L];
    logic [ADDR_W-1:0] rd_pipe [RD_LAT];

    pixel_plane_renderer_if #(.ADDR_W(ADDR_W)) vram ();

    pixel_plane_renderer #(
        .H_START(H_START), .V_START(V_START), .H_RES(H_RES), .V_RES(V_RES),
        .H_SCALE(H_SCALE), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .hs(hs), .vs(vs), .blank(blank),
        .scale2x(scale2x), .h_count(h_count), .v_count(v_count),
        .scroll_y(scroll_y),
`ifdef PIXEL_PLANE_BORDER_EN
        .border_we(border_we), .border_color(border_color),
`endif
        .vram(vram), .r(r), .g(g), .b(b), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    // VRAM stand-in: each location holds the low byte of its own address.
    always @(posedge clk) begin
        rd_pipe[0] <= vram.vram_addr;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign vram.vram_q = rd_pipe[RD_LAT-1][7:0];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (h=%0d v=%0d)", tag, obs, exp, h_count, v_count);
        end
    endtask

    task automatic check_output();
        check_value("rgb", 32'({r, g, b}), 32'(pix_hist[L-1]));
        check_value("hs_o", 32'(hs_o), 32'(hs_hist[L-1]));
        check_value("vs_o", 32'(vs_o), 32'(vs_hist[L-1]));
    endtask

    task automatic clear_hist();
        for (int k = 0; k < L; k++) begin
            pix_hist[k] = 8'h00;
            hs_hist[k]  = 1'b0;
            vs_hist[k]  = 1'b0;
        end
    endtask

    // One pixel clock: drive timing inputs, record what should emerge L cycles later.
    task automatic apply_stimulus(input int h, input int v, input logic bl, input logic [7:0] exp_pix);
        h_count = 12'(h);
        v_count = 12'(v);
        blank   = bl;
        hs      = ((h % 7) == 0);
        vs      = ((h % 7) == 0) && ((v % 2) == 1);
        for (int k = L - 1; k > 0; k--) begin
            pix_hist[k] = pix_hist[k-1];
            hs_hist[k]  = hs_hist[k-1];
            vs_hist[k]  = vs_hist[k-1];
        end
        pix_hist[0] = exp_pix;
        hs_hist[0]  = hs;
        vs_hist[0]  = vs;
        @(posedge clk);
        #1;
        if (!reset) check_output();
    endtask

    initial begin
        reset = 1'b1; hs = 1'b0; vs = 1'b0; blank = 1'b0;
        scale2x = 1'b0; scroll_y = 9'd0; h_count = 12'd0; v_count = 12'd0;
`ifdef PIXEL_PLANE_BORDER_EN
        border_we = 1'b0; border_color = 8'h00;
`endif
        clear_hist();
        apply_stimulus(0, 0, 1'b0, 8'h00);
        apply_stimulus(0, 0, 1'b0, 8'h00);
        reset = 1'b0;
        clear_hist();

        // Frame running, then reset lands mid-way through an active line.
        apply_stimulus(0, 44, 1'b0, 8'h00);
        for (int h = 150; h < 170; h++)
            apply_stimulus(h, 45, 1'b0, (h >= 160) ? 8'((h - 160) / 2) : 8'h00);
        reset = 1'b1;
        apply_stimulus(170, 45, 1'b0, 8'h00);
        apply_stimulus(171, 45, 1'b0, 8'h00);
        check_value("reset_addr", 32'(vram.vram_addr), 32'd0);
        check_value("reset_rgb", 32'({r, g, b}), 32'd0);
        check_value("reset_hs_o", 32'(hs_o), 32'd0);
        check_value("reset_vs_o", 32'(vs_o), 32'd0);
        reset = 1'b0;
        clear_hist();

        // No partial frame: black until the next frame start.
        for (int h = 172; h < 200; h++) apply_stimulus(h, 45, 1'b0, 8'h00);
        apply_stimulus(800, 45, 1'b0, 8'h00);
        for (int h = 150; h < 171; h++) apply_stimulus(h, 46, 1'b0, 8'h00);

        // Full first line with a one-cycle blank inside the window.
        apply_stimulus(0, 44, 1'b0, 8'h00);
        for (int h = 150; h <= 800; h++) begin
            apply_stimulus(h, 45, (h == 360),
                (h >= 160 && h < 800 && h != 360) ? 8'((h - 160) / 2) : 8'h00);
            check_value("addr_line0", 32'(vram.vram_addr),
                (h >= 160 && h < 800) ? 32'((h - 160) / 2) : 32'd0);
        end

        // Single-height lines: base steps by 320, 240-line window, wrap at the end.
        for (int v = 46; v <= 285; v++) begin
            apply_stimulus(159, v, 1'b0, 8'h00);
            check_value("addr_base_1x", 32'(vram.vram_addr), (v <= 284) ? 32'((v - 45) * 320) : 32'd0);
            if (v >= 284)
                for (int h = 160; h <= 162; h++)
                    apply_stimulus(h, v, 1'b0, (v == 284) ? 8'((v - 45) * 320 + (h - 160) / 2) : 8'h00);
            apply_stimulus(800, v, 1'b0, 8'h00);
        end
        for (int i = 0; i < L; i++) apply_stimulus(159, 286, 1'b0, 8'h00);

        // Doubled lines; scale2x dropped mid-frame must not take effect.
        scale2x = 1'b1;
        apply_stimulus(0, 44, 1'b0, 8'h00);
        scale2x = 1'b0;
        for (int v = 45; v <= 524; v++) begin
            apply_stimulus(159, v, 1'b0, 8'h00);
            check_value("addr_base_2x", 32'(vram.vram_addr), 32'(((v - 45) / 2) * 320));
            if (v == 46)
                for (int h = 160; h <= 162; h++)
                    apply_stimulus(h, v, 1'b0, 8'((h - 160) / 2));
            apply_stimulus(800, v, 1'b0, 8'h00);
        end

        // Scroll start at line 230 wraps after 10 lines; mid-frame scroll change held off.
        scroll_y = 9'd230;
        apply_stimulus(0, 44, 1'b0, 8'h00);
        scroll_y = 9'd250;
        for (int v = 45; v <= 284; v++) begin
            apply_stimulus(159, v, 1'b0, 8'h00);
            check_value("addr_scroll", 32'(vram.vram_addr), 32'(((185 + v) % 240) * 320));
            if (v == 45)
                for (int h = 160; h <= 162; h++)
                    apply_stimulus(h, v, 1'b0, 8'(73600 + (h - 160) / 2));
            apply_stimulus(800, v, 1'b0, 8'h00);
        end

        // Next frame picks up scroll 250, i.e. line 10.
        apply_stimulus(0, 44, 1'b0, 8'h00);
        apply_stimulus(159, 45, 1'b0, 8'h00);
        check_value("addr_scroll_next", 32'(vram.vram_addr), 32'd3200);
        apply_stimulus(800, 45, 1'b0, 8'h00);
        apply_stimulus(159, 46, 1'b0, 8'h00);
        check_value("addr_scroll_next2", 32'(vram.vram_addr), 32'd3520);

        // Border colour on non-blank pixels left of the window; blank stays black.
        for (int i = 0; i < L; i++) apply_stimulus(159, 46, 1'b1, 8'h00);
`ifdef PIXEL_PLANE_BORDER_EN
        border_color = 8'hE3;
        border_we    = 1'b1;
        bord         = 8'hE3;
`endif
        apply_stimulus(159, 46, 1'b1, 8'h00);
`ifdef PIXEL_PLANE_BORDER_EN
        border_we = 1'b0;
`endif
        for (int i = 0; i < L - 1; i++) apply_stimulus(159, 46, 1'b1, 8'h00);
        for (int i = 0; i < L; i++) apply_stimulus(159, 46, 1'b0, bord);
`ifdef PIXEL_PLANE_BORDER_EN
        check_value("border_r", 32'(r), 32'd7);
        check_value("border_g", 32'(g), 32'd0);
        check_value("border_b", 32'(b), 32'd3);
`endif
        apply_stimulus(159, 46, 1'b1, 8'h00);
        for (int i = 0; i < L; i++) apply_stimulus(159, 46, 1'b0, bord);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
